// File: rtl/vga_debug_pattern.sv
// vga_debug_pattern
//   Debug test-pattern generator for the VGA path. Takes the pixel position
//   from the timing core and produces a registered colour word. There are four
//   patterns: gradient, checkerboard, colour bars and a bouncing box. A
//   debounced push-button steps the pattern, and the new pattern is committed
//   only at a frame boundary. LEDs show the active mode and the low byte of a
//   frame counter.
//
//   Optional build macro: VGA_DEBUG_CROSSHAIR_EN
//     When defined, a 1-pixel white crosshair at the screen centre overrides
//     every pattern inside the active area. When undefined, no crosshair logic
//     is built.
//
// Ports
//   clk        in   pixel/system clock
//   rst        in   asynchronous reset, active low
//   pix_x      in   [15:0] current pixel column
//   pix_y      in   [15:0] current pixel line
//   btn_mode   in   raw mode button, active high, asynchronous to clk
//   color      out  [3*CW-1:0] {R,G,B}, registered, 1 cycle after pix_x/pix_y
//   frame_tick out  one-cycle pulse at each frame start
//   leds       out  [9:0] {mode[1:0], frame_count[7:0]}, registered
module vga_debug_pattern #(
  parameter int WIDTH           = 800,
  parameter int HEIGHT          = 600,
  parameter int CW              = 4,
  parameter int CHECK_LOG2      = 5,
  parameter int BOX_SIZE        = 32,
  parameter int BOX_SPEED       = 2,
  parameter int DEBOUNCE_CYCLES = 1000000
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [15:0]     pix_x,
  input  logic [15:0]     pix_y,
  input  logic            btn_mode,
  output logic [3*CW-1:0] color,
  output logic            frame_tick,
  output logic [9:0]      leds
);

  localparam int DB_W = $clog2(DEBOUNCE_CYCLES) + 1;
  localparam logic [CW-1:0] FULL = '1;

  logic            btn_s1, btn_s2;
  logic            db_level;
  logic [DB_W-1:0] db_cnt;
  logic [1:0]      mode, pending_mode;
  logic [15:0]     prev_y;
  logic [15:0]     frame_count;
  logic [15:0]     box_x, box_y;
  logic            dir_x, dir_y;   // 0: moving up the axis, 1: moving toward 0
  logic            frame_start;
  logic [16:0]     x_next, y_next; // {dir, position}
  logic [3*CW-1:0] color_nx;
  logic [2:0]      bar;
  logic            in_box;
  logic            active;
  logic            check_c;

  // One box step on one axis. All compares are done at 32 bits, so the
  // sums cannot truncate.
  function automatic logic [16:0] step_axis(input logic [15:0] pos,
                                            input logic        neg,
                                            input int          limit);
    logic [31:0] p;
    p = {16'b0, pos};
    if (!neg) begin
      if (p + 32'(BOX_SIZE) + 32'(BOX_SPEED) > 32'(limit))
        return {1'b1, 16'(limit - BOX_SIZE)};
      else
        return {1'b0, 16'(p + 32'(BOX_SPEED))};
    end else begin
      if (p < 32'(BOX_SPEED))
        return {1'b0, 16'b0};
      else
        return {1'b1, 16'(p - 32'(BOX_SPEED))};
    end
  endfunction

  assign frame_start = (pix_y == 16'd0) && (prev_y != 16'd0);

  always_comb begin
    x_next = step_axis(box_x, dir_x, WIDTH);
    y_next = step_axis(box_y, dir_y, HEIGHT);
  end

  always_comb begin
    active  = (32'(pix_x) < 32'(WIDTH)) && (32'(pix_y) < 32'(HEIGHT));
    check_c = pix_x[CHECK_LOG2] ^ pix_y[CHECK_LOG2];
    in_box  = (pix_x >= box_x) && (32'(pix_x) < 32'(box_x) + 32'(BOX_SIZE)) &&
              (pix_y >= box_y) && (32'(pix_y) < 32'(box_y) + 32'(BOX_SIZE));

    // The bar index is (pix_x*8)/WIDTH. Each threshold k*WIDTH is a constant,
    // so the chain of compares needs no divider.
    bar = 3'd0;
    for (int k = 1; k < 8; k++) begin
      if ({13'b0, pix_x, 3'b0} >= 32'(k * WIDTH)) bar = 3'(k);
    end

    color_nx = '0;
    case (mode)
      2'd0: color_nx = {pix_x[CW-1:0], pix_y[CW-1:0], {CW{1'b0}}};
      2'd1: color_nx = {3{{CW{check_c}}}};
      2'd2: color_nx = {{CW{bar[2]}}, {CW{bar[1]}}, {CW{bar[0]}}};
      default: color_nx = in_box ? {3{FULL}} : {{2*CW{1'b0}}, FULL};
    endcase

`ifdef VGA_DEBUG_CROSSHAIR_EN
    if ((pix_x == 16'(WIDTH / 2)) || (pix_y == 16'(HEIGHT / 2)))
      color_nx = {3{FULL}};
`endif

    if (!active) color_nx = '0;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      btn_s1       <= 1'b0;
      btn_s2       <= 1'b0;
      db_level     <= 1'b0;
      db_cnt       <= '0;
      mode         <= 2'd0;
      pending_mode <= 2'd0;
      prev_y       <= 16'd0;
      frame_tick   <= 1'b0;
      frame_count  <= 16'd0;
      box_x        <= 16'd0;
      box_y        <= 16'd0;
      dir_x        <= 1'b0;
      dir_y        <= 1'b0;
      color        <= '0;
      leds         <= 10'd0;
    end else begin
      btn_s1 <= btn_mode;
      btn_s2 <= btn_s1;

      // The counter runs only while the synchronised level disagrees with
      // the accepted level. Any bounce back restarts it from 0.
      if (btn_s2 == db_level) begin
        db_cnt <= '0;
      end else if (db_cnt == DB_W'(DEBOUNCE_CYCLES - 1)) begin
        db_level <= btn_s2;
        db_cnt   <= '0;
        if (btn_s2) pending_mode <= pending_mode + 2'd1;
      end else begin
        db_cnt <= db_cnt + DB_W'(1);
      end

      prev_y     <= pix_y;
      frame_tick <= frame_start;

      // Mode commit and box motion both happen only at a frame boundary.
      if (frame_tick) begin
        mode        <= pending_mode;
        frame_count <= frame_count + 16'd1;
        box_x       <= x_next[15:0];
        dir_x       <= x_next[16];
        box_y       <= y_next[15:0];
        dir_y       <= y_next[16];
      end

      color <= color_nx;
      leds  <= {mode, frame_count[7:0]};
    end
  end

endmodule

// File: tb/tb_vga_debug_pattern.sv
module tb_vga_debug_pattern;

  localparam int WIDTH      = 64;
  localparam int HEIGHT     = 48;
  localparam int CW         = 4;
  localparam int CHECK_LOG2 = 5;
  localparam int BOX_SIZE   = 8;
  localparam int BOX_SPEED  = 5;
  localparam int DEB        = 4;
  localparam int W          = 3 * CW + 1 + 10;  // {color, frame_tick, leds}

  // ---------------- clock / reset ----------------
  logic            clk = 1'b0;
  logic            rst = 1'b0;
  logic [15:0]     pix_x = 16'd0;
  logic [15:0]     pix_y = 16'd0;
  logic            btn_mode = 1'b0;
  logic [3*CW-1:0] color;
  logic            frame_tick;
  logic [9:0]      leds;

  always #5 clk = ~clk;

  vga_debug_pattern #(
    .WIDTH(WIDTH), .HEIGHT(HEIGHT), .CW(CW), .CHECK_LOG2(CHECK_LOG2),
    .BOX_SIZE(BOX_SIZE), .BOX_SPEED(BOX_SPEED), .DEBOUNCE_CYCLES(DEB)
  ) dut (
    .clk(clk), .rst(rst), .pix_x(pix_x), .pix_y(pix_y), .btn_mode(btn_mode),
    .color(color), .frame_tick(frame_tick), .leds(leds)
  );

  // ---------------- scoreboard state ----------------
  int total = 0;
  int bad   = 0;
  logic [W-1:0] exp_q[$];
  logic [W-1:0] mon_e;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  int m_mode, m_pending, m_count, m_bx, m_by, m_dx, m_dy, m_last_y, m_apply;

  function automatic logic [11:0] ref_color(input int x, input int y);
    int bar;
    logic [3:0] r, g, b;
    if (x >= WIDTH || y >= HEIGHT) return 12'h000;
    case (m_mode)
      0: return {4'(x % 16), 4'(y % 16), 4'h0};
      1: return ((x / 32) % 2 != (y / 32) % 2) ? 12'hFFF : 12'h000;
      2: begin
        bar = (x * 8) / WIDTH;
        r = ((bar / 4) % 2 == 1) ? 4'hF : 4'h0;
        g = ((bar / 2) % 2 == 1) ? 4'hF : 4'h0;
        b = (bar % 2 == 1) ? 4'hF : 4'h0;
        return {r, g, b};
      end
      default:
        return (x >= m_bx && x < m_bx + BOX_SIZE && y >= m_by && y < m_by + BOX_SIZE)
               ? 12'hFFF : 12'h00F;
    endcase
  endfunction

  task automatic move(inout int p, inout int d, input int lim);
    if (d > 0) begin
      if (p + BOX_SIZE + BOX_SPEED > lim) begin p = lim - BOX_SIZE; d = -1; end
      else p = p + BOX_SPEED;
    end else begin
      if (p < BOX_SPEED) begin p = 0; d = 1; end
      else p = p - BOX_SPEED;
    end
  endtask

  task automatic model_reset();
    m_mode = 0; m_pending = 0; m_count = 0;
    m_bx = 0; m_by = 0; m_dx = 1; m_dy = 1;
    m_apply = 0;
  endtask

  task automatic apply_frame();
    m_mode  = m_pending;
    m_count = (m_count + 1) % 65536;
    move(m_bx, m_dx, WIDTH);
    move(m_by, m_dy, HEIGHT);
  endtask

  // ---------------- driver tasks ----------------
  // One pixel per clock. A new frame becomes visible two pixels after its
  // first line-0 pixel: tick one cycle later, commit on the following edge.
  task automatic issue(input int x, input int y);
    logic tick;
    @(negedge clk);
    if (m_apply > 0) begin
      m_apply--;
      if (m_apply == 0) apply_frame();
    end
    pix_x = 16'(x);
    pix_y = 16'(y);
    tick  = (y == 0) && (m_last_y != 0);
    exp_q.push_back({ref_color(x, y), tick, 2'(m_mode), 8'(m_count)});
    if (tick) m_apply = 2;
    m_last_y = y;
  endtask

  task automatic rnd_pix();
    issue($urandom_range(0, WIDTH + 3), $urandom_range(1, HEIGHT + 3));
  endtask

  task automatic frame();
    rnd_pix();
    issue($urandom_range(0, WIDTH + 3), 0);
    rnd_pix();
    rnd_pix();
  endtask

  task automatic press();
    m_pending = (m_pending + 1) % 4;
    btn_mode = 1'b1;
    repeat (8) rnd_pix();
    btn_mode = 1'b0;
    repeat (8) rnd_pix();
  endtask

  task automatic glitch();
    btn_mode = 1'b1;
    repeat (3) rnd_pix();
    btn_mode = 1'b0;
    repeat (8) rnd_pix();
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("rst_color", 32'(color), 32'd0);
    check("rst_tick", 32'(frame_tick), 32'd0);
    check("rst_leds", 32'(leds), 32'd0);
    repeat (3) @(negedge clk);
    check("rst_hold_color", 32'(color), 32'd0);
    check("rst_hold_leds", 32'(leds), 32'd0);
    model_reset();
    exp_q.delete();
    m_last_y = int'(pix_y);  // the first edge after release loads prev_y from this
    rst = 1'b1;
  endtask

  // ---------------- monitor ----------------
  always @(posedge clk) begin
    #1;
    if (exp_q.size() > 0) begin
      mon_e = exp_q.pop_front();
      check("color", 32'(color), 32'(mon_e[W-1 -: 12]));
      check("frame_tick", 32'(frame_tick), 32'(mon_e[10]));
      check("leds", 32'(leds), 32'(mon_e[9:0]));
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    model_reset();
    m_last_y = 0;
    do_reset();

    // gradient, blanking edges
    repeat (20) rnd_pix();
    issue(16'h23, 16'h17);
    issue(WIDTH, 10);
    issue(10, HEIGHT);
    issue(WIDTH - 1, HEIGHT - 1);

    // short glitch is rejected, then a clean press commits at the next frame
    glitch();
    frame();
    repeat (10) rnd_pix();
    press();
    repeat (5) rnd_pix();
    frame();
    repeat (20) rnd_pix();

    // checkerboard
    issue(31, 0);
    issue(32, 0);
    issue(32, 32);
    issue(31, 31);
    repeat (20) rnd_pix();

    // five presses in one frame: 1 + 5 -> mode 2, colour bars
    repeat (5) press();
    frame();
    for (int x = 0; x < WIDTH + 4; x++) issue(x, 5);
    repeat (20) rnd_pix();

    // reset mid-frame while in mode 2
    issue(40, 20);
    do_reset();
    repeat (10) rnd_pix();

    // bouncing box: 13 frames covering clamp and reversal on x
    repeat (3) press();
    frame();
    for (int f = 0; f < 13; f++) begin
      frame();
      issue(m_bx, m_by + 1);
      issue(m_bx + BOX_SIZE, m_by + 1);
      issue(m_bx + BOX_SIZE - 1, m_by + BOX_SIZE - 1);
      repeat (4) rnd_pix();
    end
    repeat (30) rnd_pix();

    // many tiny frames so the displayed frame count wraps through 0
    for (int f = 0; f < 260; f++) begin
      issue($urandom_range(0, WIDTH + 3), $urandom_range(1, HEIGHT + 3));
      issue($urandom_range(0, WIDTH + 3), 0);
    end
    repeat (10) rnd_pix();

    repeat (3) @(negedge clk);
    check("queue_drained", 32'(exp_q.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
